// File: rtl/tdm_demux.sv
// Receive side of the 2-channel TDM serial link: locks to frame sync, deserialises
// channel A and B words MSB-first and hands them out on independent valid/ready ports.
module tdm_demux #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sync,
   input  logic             clr,
   output logic [WIDTH-1:0] data_a,
   output logic             valid_a,
   input  logic             ready_a,
   output logic [WIDTH-1:0] data_b,
   output logic             valid_b,
   input  logic             ready_b,
   output logic             overrun_a,
   output logic             overrun_b,
   output logic             frame_err,
   output logic             locked
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {StHunt, StChA, StChB} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
   logic             done_a_q, done_a_d, done_b_q, done_b_d;
   logic             frame_err_q, frame_err_d;

   logic [WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
   logic             valid_a_q, valid_a_d, valid_b_q, valid_b_d;
   logic             ovr_a_q, ovr_a_d, ovr_b_q, ovr_b_d;

   assign cnt_inc  = cnt_q + CW'(1);
   assign sr_shift = {sr_q[WIDTH-2:0], sin};

   // Framing FSM. StChA with cnt_q == 0 is only reached right after a B word,
   // so that state/count pair marks the frame-boundary bit.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      done_a_d    = 1'b0;
      done_b_d    = 1'b0;
      frame_err_d = 1'b0;
      unique case (state_q)
         StHunt: begin
            if (sync) begin
               sr_d    = sr_shift;
               cnt_d   = CW'(1);
               state_d = StChA;
            end
         end
         StChA: begin
            if (cnt_q == '0) begin
               if (sync) begin
                  sr_d  = sr_shift;
                  cnt_d = CW'(1);
               end else begin
                  frame_err_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = StHunt;
               end
            end else if (sync) begin
               frame_err_d = 1'b1;
               sr_d        = sr_shift;
               cnt_d       = CW'(1);
            end else begin
               sr_d = sr_shift;
               if (cnt_inc == CW'(WIDTH)) begin
                  cnt_d    = '0;
                  state_d  = StChB;
                  done_a_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         StChB: begin
            sr_d = sr_shift;
            if (sync) begin
               frame_err_d = 1'b1;
               cnt_d       = CW'(1);
               state_d     = StChA;
            end else if (cnt_inc == CW'(WIDTH)) begin
               cnt_d    = '0;
               state_d  = StChA;
               done_b_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = StHunt;
      endcase
   end

   // Output stage: sr_q still holds the completed word one edge after done_x is set.
   always_comb begin
      data_a_d  = data_a_q;
      valid_a_d = valid_a_q;
      ovr_a_d   = ovr_a_q & ~clr;
      if (done_a_q) begin
         if (valid_a_q && !ready_a) begin
            ovr_a_d = 1'b1;
         end else begin
            data_a_d  = sr_q;
            valid_a_d = 1'b1;
         end
      end else if (valid_a_q && ready_a) begin
         valid_a_d = 1'b0;
      end

      data_b_d  = data_b_q;
      valid_b_d = valid_b_q;
      ovr_b_d   = ovr_b_q & ~clr;
      if (done_b_q) begin
         if (valid_b_q && !ready_b) begin
            ovr_b_d = 1'b1;
         end else begin
            data_b_d  = sr_q;
            valid_b_d = 1'b1;
         end
      end else if (valid_b_q && ready_b) begin
         valid_b_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StHunt;
         cnt_q       <= '0;
         sr_q        <= '0;
         done_a_q    <= 1'b0;
         done_b_q    <= 1'b0;
         frame_err_q <= 1'b0;
         data_a_q    <= '0;
         data_b_q    <= '0;
         valid_a_q   <= 1'b0;
         valid_b_q   <= 1'b0;
         ovr_a_q     <= 1'b0;
         ovr_b_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         done_a_q    <= done_a_d;
         done_b_q    <= done_b_d;
         frame_err_q <= frame_err_d;
         data_a_q    <= data_a_d;
         data_b_q    <= data_b_d;
         valid_a_q   <= valid_a_d;
         valid_b_q   <= valid_b_d;
         ovr_a_q     <= ovr_a_d;
         ovr_b_q     <= ovr_b_d;
      end
   end

   assign data_a    = data_a_q;
   assign valid_a   = valid_a_q;
   assign data_b    = data_b_q;
   assign valid_b   = valid_b_q;
   assign overrun_a = ovr_a_q;
   assign overrun_b = ovr_b_q;
   assign frame_err = frame_err_q;
   assign locked    = (state_q == StChA) || (state_q == StChB);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: table-driven frames plus hand-written corner sequences,
// with per-channel scoreboard queues popped on every valid/ready transfer.
module tb_tdm_demux;

   localparam int unsigned W = 8;

   logic         clk, rst, sin, sync, clr, ready_a, ready_b;
   logic [W-1:0] data_a, data_b;
   logic         valid_a, valid_b, overrun_a, overrun_b, frame_err, locked;

   int checks = 0;
   int errors = 0;
   int fe_count = 0;
   int exp_fe = 0;
   int stray = 0;

   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_a;
      logic [W-1:0] exp_b;
   } vec_t;

   vec_t vecs[6];

   tdm_demux #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .sync      (sync),
      .clr       (clr),
      .data_a    (data_a),
      .valid_a   (valid_a),
      .ready_a   (ready_a),
      .data_b    (data_b),
      .valid_b   (valid_b),
      .ready_b   (ready_b),
      .overrun_a (overrun_a),
      .overrun_b (overrun_b),
      .frame_err (frame_err),
      .locked    (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: a transfer happens on the next posedge when valid && ready.
   always @(negedge clk) begin
      if (frame_err) fe_count++;
      if (valid_a && ready_a) begin
         check("a_transfer_expected", qa.size() != 0, 1);
         if (qa.size() != 0) check("a_word", data_a, qa.pop_front());
      end
      if (valid_b && ready_b) begin
         check("b_transfer_expected", qb.size() != 0, 1);
         if (qb.size() != 0) check("b_word", data_b, qb.pop_front());
      end
   end

   task automatic send_bit(input logic s, input logic y);
      sin  = s;
      sync = y;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b, input bit lat);
      for (int i = 0; i < 2 * W; i++) begin
         logic bt;
         bt = (i < W) ? a[W-1-i] : b[2*W-1-i];
         send_bit(bt, i == 0);
         if (lat && i == 0) check("locked_after_sync", locked, 1);
         if (lat && i == W - 1) check("valid_a_before_latency", valid_a, 0);
         if (lat && i == W) begin
            check("valid_a_latency", valid_a, 1);
            check("data_a_latency", data_a, a);
         end
      end
   endtask

   initial begin
      vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[2] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
      vecs[4] = '{8'h01, 8'h80, 8'h01, 8'h80};
      vecs[5] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};

      rst = 1'b1; sin = 1'b0; sync = 1'b0; clr = 1'b0;
      ready_a = 1'b1; ready_b = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid_a", valid_a, 0);
      check("rst_valid_b", valid_b, 0);
      check("rst_data_a", data_a, 0);
      check("rst_data_b", data_b, 0);
      check("rst_overrun", {overrun_a, overrun_b}, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_locked", locked, 0);
      rst = 1'b0;

      // Back-to-back clean frames
      foreach (vecs[k]) begin
         qa.push_back(vecs[k].exp_a);
         qb.push_back(vecs[k].exp_b);
         send_frame(vecs[k].a, vecs[k].b, 1'b1);
      end
      check("t1_no_frame_err", fe_count, 0);
      check("t1_locked", locked, 1);
      idle(3);
      exp_fe++;
      check("t1_fe_count", fe_count, exp_fe);
      check("t1_unlocked", locked, 0);

      // Stall A for two frames: second word overruns
      ready_a = 1'b0;
      qa.push_back(8'h11); qb.push_back(8'hB1);
      send_frame(8'h11, 8'hB1, 1'b0);
      check("t2_hold_data", data_a, 8'h11);
      check("t2_hold_valid", valid_a, 1);
      check("t2_no_overrun_yet", overrun_a, 0);
      qb.push_back(8'hB2);
      send_frame(8'h22, 8'hB2, 1'b0);
      check("t2_overrun_set", overrun_a, 1);
      check("t2_old_word_kept", data_a, 8'h11);
      check("t2_valid_kept", valid_a, 1);
      check("t2_b_unaffected", overrun_b, 0);
      idle(3);
      exp_fe++;
      ready_a = 1'b1;
      send_bit(1'b0, 1'b0);
      check("t2_valid_cleared", valid_a, 0);
      check("t2_overrun_sticky", overrun_a, 1);
      clr = 1'b1;
      send_bit(1'b0, 1'b0);
      clr = 1'b0;
      check("t2_overrun_cleared", overrun_a, 0);

      // Accept on the same edge a new B word lands
      ready_b = 1'b0;
      qa.push_back(8'hC1); qb.push_back(8'h66);
      send_frame(8'hC1, 8'h66, 1'b0);
      qa.push_back(8'hC2); qb.push_back(8'h77);
      send_frame(8'hC2, 8'h77, 1'b0);
      check("t3_b_held", data_b, 8'h66);
      ready_b = 1'b1;
      send_bit(1'b0, 1'b0);
      exp_fe++;
      ready_b = 1'b0;
      check("t3_valid_b", valid_b, 1);
      check("t3_data_b", data_b, 8'h77);
      check("t3_no_overrun_b", overrun_b, 0);
      ready_b = 1'b1;
      idle(3);
      check("t3_fe_count", fe_count, exp_fe);

      // Sync at A bit 4 truncates the frame and restarts A
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      qa.push_back(8'hF0); qb.push_back(8'h5D);
      send_frame(8'hF0, 8'h5D, 1'b1);
      exp_fe++;
      check("t4_resync_fe", fe_count, exp_fe);
      idle(3);
      exp_fe++;
      check("t4_fe_count", fe_count, exp_fe);

      // Missing sync at the boundary
      qa.push_back(8'h12); qb.push_back(8'h34);
      send_frame(8'h12, 8'h34, 1'b0);
      send_bit(1'b0, 1'b0);
      exp_fe++;
      check("t5_frame_err", frame_err, 1);
      check("t5_unlocked", locked, 0);
      check("t5_valid_b", valid_b, 1);
      check("t5_data_b", data_b, 8'h34);
      send_bit(1'b1, 1'b0);
      check("t5_frame_err_pulse", frame_err, 0);
      for (int k = 0; k < 20; k++) begin
         send_bit(k[0], 1'b0);
         if (valid_a || valid_b) stray++;
      end
      check("t5_no_valid_in_hunt", stray, 0);
      qa.push_back(8'h56); qb.push_back(8'h78);
      send_frame(8'h56, 8'h78, 1'b1);
      idle(3);
      exp_fe++;
      check("t5_fe_count", fe_count, exp_fe);

      // Reset mid-frame with pending state
      ready_a = 1'b0; ready_b = 1'b0;
      send_frame(8'h9A, 8'hBC, 1'b0);
      send_frame(8'hDE, 8'hF1, 1'b0);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      check("t6_pre_valid_b", valid_b, 1);
      check("t6_pre_overrun_a", overrun_a, 1);
      rst = 1'b1;
      send_bit(1'b1, 1'b0);
      check("t6_rst_valid", {valid_a, valid_b}, 0);
      check("t6_rst_data_a", data_a, 0);
      check("t6_rst_data_b", data_b, 0);
      check("t6_rst_overrun", {overrun_a, overrun_b}, 0);
      check("t6_rst_fe_locked", {frame_err, locked}, 0);
      rst = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
      send_bit(1'b0, 1'b0);
      qa.push_back(8'hE7); qb.push_back(8'h19);
      send_frame(8'hE7, 8'h19, 1'b1);
      idle(3);
      exp_fe++;

      check("final_fe_count", fe_count, exp_fe);
      check("final_qa_empty", qa.size(), 0);
      check("final_qb_empty", qb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
